l1_refill_ctrl: RTL
===================

# l1_refill_ctrl

Miss handler directly downstream of the L1 `cache`: accepts one miss at a time, writes back the dirty victim line word-by-word, fetches the missing line word-by-word from backing memory, then returns the assembled line to the cache. It owns the only path between the cache and the memory bus. One miss is outstanding at a time, with no request buffering.

## Interface
Parameters:
- `ADDR_WIDTH`, 32, byte-address width.
- `DATA_WIDTH`, 32, word and memory-beat width; fixed multiple of 8.
- `WORDS_PER_LINE`, 2, beats per line; power of two, ≥1.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `miss_valid`  in  1  cache presents a miss.
- `miss_ready`  out  1  controller idle; a miss is accepted on `miss_valid && miss_ready`.
- `miss_addr`  in  ADDR_WIDTH  address of the missing line; low offset bits are ignored.
- `miss_dirty`  in  1  victim needs writeback.
- `victim_addr`  in  ADDR_WIDTH  victim line address; offset bits are ignored.
- `victim_data`  in  DATA_WIDTH*WORDS_PER_LINE  victim line; word i is at `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `fill_valid`  out  1  one-cycle pulse: the fill line is valid.
- `fill_addr`  out  ADDR_WIDTH  line-aligned address of the fill.
- `fill_data`  out  DATA_WIDTH*WORDS_PER_LINE  fetched line, same word packing as `victim_data`.
- `mem_req`  out  1  memory beat request.
- `mem_we`  out  1  1 = write beat, 0 = read beat.
- `mem_addr`  out  ADDR_WIDTH  byte address of the beat.
- `mem_wdata`  out  DATA_WIDTH  write data.
- `mem_ack`  in  1  beat completes on `mem_req && mem_ack`; ignored when `mem_req` = 0.
- `mem_rdata`  in  DATA_WIDTH  read data, valid in the ack cycle.

## Operation
- States: IDLE, WB, FILL, RESP.
- IDLE
  - `miss_ready` = 1.
  - On accept: latch `miss_addr` and `victim_addr` (both line-aligned: low log2(WORDS_PER_LINE)+log2(DATA_WIDTH/8) bits forced to 0), plus `victim_data`.
  - Go to WB if `miss_dirty`, else FILL.
- WB
  - Beat i: `mem_we`=1, `mem_addr` = victim base + i*(DATA_WIDTH/8), `mem_wdata` = victim word i.
  - After the ack of beat WORDS_PER_LINE-1: go to FILL with the beat counter at 0.
- FILL
  - Beat i: `mem_we`=0, `mem_addr` = miss base + i*(DATA_WIDTH/8).
  - On ack, `mem_rdata` is stored into line-buffer word i.
  - After the last ack: go to RESP.
- RESP
  - `fill_valid`=1 for exactly one cycle; `fill_addr` = miss base; `fill_data` = buffer.
  - Go to IDLE.
- Beat counter: width log2(WORDS_PER_LINE) (minimum 1 bit); wraps to 0 after the last beat.
- Address arithmetic: modulo 2^ADDR_WIDTH, no carry out of the line (base is aligned).
- `miss_valid` outside IDLE is ignored; the cache must hold it until accepted.
- `fill_data` and `fill_addr` hold their value after RESP until the next RESP.

## Timing
- All `mem_*` outputs, `fill_*` outputs and state are registered. `miss_ready` is decoded from state.
- `mem_req` rises the cycle after accept.
  - Next beat: on an ack, the following cycle presents the next beat with `mem_req` still high (back-to-back). There is no idle cycle between WB and FILL.
  - Last fill beat: `mem_req` drops the cycle after its ack.
  - Wait states: `mem_req`, `mem_addr`, `mem_we` and `mem_wdata` are stable while ack is low.
- Latency with ack tied high, accept at cycle 0, N = WORDS_PER_LINE:
  - Clean miss: fill beats in cycles 1..N; `fill_valid` in cycle N+1; `miss_ready` = 1 in cycle N+2.
  - Dirty miss: adds N cycles.
- Reset (asynchronous, any state including mid-beat):
  - Behaviour: state goes to IDLE and all partial work is discarded.
  - Output values: `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `fill_valid`=0, `fill_addr`=0, `fill_data`=0, `miss_ready`=1.
- Release: first accept is possible on the first rising edge with `rst_n`=1.

## Structure
- Package `cache_pkg`:
  - state enum (IDLE/WB/FILL/RESP);
  - `BYTES_PER_WORD`, `LINE_OFFSET_W` localparams;
  - `line_base()` align function.
- Sub-module `line_buffer`: WORDS_PER_LINE×DATA_WIDTH register file, one write port (index, data, enable), full-line parallel read; instantiated once for fill assembly.
- Victim data is latched into a plain register in the top; no second instance.

## Test plan
- Clean miss, N=2, ack tied 1:
  - Stimulus: `miss_addr`=0x0000_1234, memory returns 0xAAAA_0001 then 0xBBBB_0002.
  - Required: reads at 0x1230 and 0x1234; `fill_valid` in cycle 3; `fill_addr`=0x1230; `fill_data`=0xBBBB_0002_AAAA_0001.
- Dirty miss:
  - Stimulus: `victim_addr`=0x0000_0040, `victim_data`=0x2222_2222_1111_1111, `miss_addr`=0x0000_0080.
  - Required: writes 0x40←0x1111_1111 and 0x44←0x2222_2222, then reads 0x80 and 0x84; `fill_valid` in cycle 5.
- Wait states:
  - Stimulus: ack held low for 3 cycles on each beat.
  - Required: `mem_*` outputs stable while waiting; total clean-miss latency is 9 cycles to `fill_valid`.
- Busy:
  - Stimulus: `miss_valid` held high during FILL.
  - Required: `miss_ready`=0, no second accept until the cycle after `fill_valid`; the held miss is then accepted.
- Reset mid-WB:
  - Stimulus: `rst_n` dropped after beat 0 ack.
  - Required: outputs go to reset values immediately; no `fill_valid`; a new miss after release starts from beat 0.
- Wrap:
  - Stimulus: `miss_addr`=0xFFFF_FFFC, N=2.
  - Required: reads at 0xFFFF_FFF8 and 0xFFFF_FFFC; `fill_addr`=0xFFFF_FFF8.

Source files
------------

// File: rtl/cache_pkg.sv
// cache_pkg: shared types and helpers for the L1 refill path.
// Holds the refill FSM state type and line-alignment helpers.
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WB,
        FILL,
        RESP
    } state_t;

    // Defaults for a 32-bit word, 2-word line.
    localparam int BYTES_PER_WORD = 4;
    localparam int LINE_OFFSET_W  = 3;

    // Clear the low off_w bits of an address.
    function automatic logic [63:0] line_base(
        input logic [63:0] addr,
        input int          off_w
    );
        return addr & ~((64'd1 << off_w) - 64'd1);
    endfunction

endpackage

// File: rtl/line_buffer.sv
// line_buffer: WORDS x DATA_WIDTH register file, one write port,
// full-line parallel read. Ports: clk, rst_n, we, idx, wdata, line.
module line_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int WORDS      = 2,
    parameter int IDX_W      = (WORDS > 1) ? $clog2(WORDS) : 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        we,
    input  logic [IDX_W-1:0]            idx,
    input  logic [DATA_WIDTH-1:0]       wdata,
    output logic [DATA_WIDTH*WORDS-1:0] line
);

    logic [DATA_WIDTH-1:0] mem [WORDS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < WORDS; i++)
                mem[i] <= '0;
        end else if (we) begin
            mem[idx] <= wdata;
        end
    end

    for (genvar g = 0; g < WORDS; g++) begin : g_rd
        assign line[g*DATA_WIDTH +: DATA_WIDTH] = mem[g];
    end

endmodule

// File: rtl/l1_refill_ctrl.sv
// l1_refill_ctrl: single-miss L1 refill controller.
// Ports: miss_* (cache request), fill_* (line return),
// mem_* (beat bus to backing memory), clk, rst_n.
module l1_refill_ctrl
    import cache_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int WORDS_PER_LINE = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  miss_valid,
    output logic                  miss_ready,
    input  logic [ADDR_WIDTH-1:0] miss_addr,
    input  logic                  miss_dirty,
    input  logic [ADDR_WIDTH-1:0] victim_addr,
    input  logic [DATA_WIDTH*WORDS_PER_LINE-1:0] victim_data,
    output logic                  fill_valid,
    output logic [ADDR_WIDTH-1:0] fill_addr,
    output logic [DATA_WIDTH*WORDS_PER_LINE-1:0] fill_data,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int BPW   = DATA_WIDTH / 8;
    localparam int BSH   = $clog2(BPW);
    localparam int OFF_W = $clog2(WORDS_PER_LINE) + BSH;
    localparam int CNT_W =
        (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;
    localparam int LW    = DATA_WIDTH * WORDS_PER_LINE;
    localparam logic [CNT_W-1:0] LAST =
        CNT_W'(WORDS_PER_LINE - 1);

    state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_nx;

    logic [ADDR_WIDTH-1:0] mbase_q, mbase_d;
    logic [ADDR_WIDTH-1:0] vbase_q, vbase_d;
    logic [LW-1:0]         vdata_q, vdata_d;

    logic                  req_d, we_d, fv_d;
    logic [ADDR_WIDTH-1:0] addr_d, faddr_d;
    logic [DATA_WIDTH-1:0] wdata_d;
    logic [LW-1:0]         fdata_d;

    logic          buf_we;
    logic [LW-1:0] buf_line, merged;

    logic ack, last;
    logic [ADDR_WIDTH-1:0] miss_base, vic_base;

    assign ack    = mem_req && mem_ack;
    assign last   = (cnt_q == LAST);
    assign cnt_nx = cnt_q + 1'b1;

    assign miss_ready = (state_q == IDLE);

    assign miss_base = ADDR_WIDTH'(
        line_base(64'(miss_addr), OFF_W));
    assign vic_base  = ADDR_WIDTH'(
        line_base(64'(victim_addr), OFF_W));

    line_buffer #(
        .DATA_WIDTH(DATA_WIDTH),
        .WORDS     (WORDS_PER_LINE),
        .IDX_W     (CNT_W)
    ) u_buf (
        .clk  (clk),
        .rst_n(rst_n),
        .we   (buf_we),
        .idx  (cnt_q),
        .wdata(mem_rdata),
        .line (buf_line)
    );

    // Last fill beat bypasses the buffer so RESP sees a full line.
    always_comb begin
        merged = buf_line;
        merged[int'(cnt_q)*DATA_WIDTH +: DATA_WIDTH] = mem_rdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (miss_valid)
                state_d = miss_dirty ? WB : FILL;
            WB:   if (ack && last) state_d = FILL;
            FILL: if (ack && last) state_d = RESP;
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d   = cnt_q;
        mbase_d = mbase_q;
        vbase_d = vbase_q;
        vdata_d = vdata_q;
        req_d   = mem_req;
        we_d    = mem_we;
        addr_d  = mem_addr;
        wdata_d = mem_wdata;
        fv_d    = 1'b0;
        faddr_d = fill_addr;
        fdata_d = fill_data;
        buf_we  = 1'b0;
        unique case (state_q)
            IDLE: if (miss_valid) begin
                mbase_d = miss_base;
                vbase_d = vic_base;
                vdata_d = victim_data;
                cnt_d   = '0;
                req_d   = 1'b1;
                we_d    = miss_dirty;
                addr_d  = miss_dirty ? vic_base : miss_base;
                wdata_d = victim_data[DATA_WIDTH-1:0];
            end
            WB: if (ack) begin
                if (last) begin
                    cnt_d  = '0;
                    we_d   = 1'b0;
                    addr_d = mbase_q;
                end else begin
                    cnt_d   = cnt_nx;
                    addr_d  = vbase_q
                            + (ADDR_WIDTH'(cnt_nx) << BSH);
                    wdata_d = vdata_q[int'(cnt_nx)*DATA_WIDTH
                                      +: DATA_WIDTH];
                end
            end
            FILL: if (ack) begin
                buf_we = 1'b1;
                if (last) begin
                    cnt_d   = '0;
                    req_d   = 1'b0;
                    fv_d    = 1'b1;
                    faddr_d = mbase_q;
                    fdata_d = merged;
                end else begin
                    cnt_d  = cnt_nx;
                    addr_d = mbase_q
                           + (ADDR_WIDTH'(cnt_nx) << BSH);
                end
            end
            RESP: ;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mbase_q    <= '0;
            vbase_q    <= '0;
            vdata_q    <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            fill_valid <= 1'b0;
            fill_addr  <= '0;
            fill_data  <= '0;
        end else begin
            mbase_q    <= mbase_d;
            vbase_q    <= vbase_d;
            vdata_q    <= vdata_d;
            mem_req    <= req_d;
            mem_we     <= we_d;
            mem_addr   <= addr_d;
            mem_wdata  <= wdata_d;
            fill_valid <= fv_d;
            fill_addr  <= faddr_d;
            fill_data  <= fdata_d;
        end
    end

endmodule
